// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared definitions for the hardwired control sequencer: IR field
//   positions, supported opcodes, sequencer state encoding and small
//   decode helpers.
package control_sequencer_pkg;

  // IR field bit positions
  localparam int unsigned IR_OP_HI = 31;
  localparam int unsigned IR_OP_LO = 27;
  localparam int unsigned IR_RA_HI = 26;
  localparam int unsigned IR_RA_LO = 23;
  localparam int unsigned IR_RB_HI = 22;
  localparam int unsigned IR_RB_LO = 19;
  localparam int unsigned IR_RC_HI = 18;
  localparam int unsigned IR_RC_LO = 15;

  // R-format ALU/shift operations
  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_SHR  = 5'h04;
  localparam logic [4:0] OP_SHRA = 5'h05;
  localparam logic [4:0] OP_SHL  = 5'h06;
  localparam logic [4:0] OP_ROR  = 5'h07;
  localparam logic [4:0] OP_ROL  = 5'h08;

  // Control instructions
  localparam logic [4:0] OP_NOP  = 5'h19;
  localparam logic [4:0] OP_HALT = 5'h1A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_t;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op <= OP_ROL);
  endfunction

  function automatic logic is_legal_op(input logic [4:0] op);
    return is_alu_op(op) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/control_sequencer_reg_field_decoder.sv
// reg_field_decoder
//   Converts a 4-bit register field into a one-hot NUM_REGS-wide select.
//   Output is all zero when disabled or when the field addresses a
//   register beyond NUM_REGS.
// Ports:
//   i_field  in  4         register number
//   i_en     in  1         decode enable
//   o_onehot out NUM_REGS  one-hot select
module reg_field_decoder #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [3:0]          i_field,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      o_onehot[i] = i_en && (i == int'(i_field));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for the DataPath. Fetches an instruction
//   (T0-T2), decodes IR in T3 and sequences 3-register ALU/shift
//   instructions through T3-T5. Outputs are Moore: decoded from the
//   current state and ir only.
// Ports:
//   clock, clear            clock (rising edge), async active-high reset
//   run                     level enable to leave IDLE / continue after retire
//   mem_ready               memory read data valid this cycle
//   ir[31:0]                current IR contents from DataPath
//   PCout..Yin              single-bit datapath strobes
//   Rin/Rout[NUM_REGS]      one-hot register write / bus-drive enables
//   opcode[4:0]             ALU operation select
//   halted                  high while in HALT
//   illegal                 high in T2/T3 when ir holds an unsupported opcode
//   instr_count             instructions retired since reset (wraps)
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   run,
  input  logic                   mem_ready,
  input  logic [31:0]            ir,
  output logic                   PCout,
  output logic                   IncPC,
  output logic                   MARin,
  output logic                   Zin,
  output logic                   Zlo_out,
  output logic                   PCin,
  output logic                   Read,
  output logic                   MDRin,
  output logic                   MDRout,
  output logic                   IRin,
  output logic                   Yin,
  output logic [NUM_REGS-1:0]    Rin,
  output logic [NUM_REGS-1:0]    Rout,
  output logic [4:0]             opcode,
  output logic                   halted,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  state_t r_state;
  state_t w_next;

  logic [COUNT_WIDTH-1:0] r_count;

  logic [4:0] w_op;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_is_alu;
  logic       w_is_nop;
  logic       w_is_halt;
  logic       w_is_legal;
  logic       w_retire;
  logic       w_unused_ir;

  logic [NUM_REGS-1:0] w_rout_rb;
  logic [NUM_REGS-1:0] w_rout_rc;
  logic [NUM_REGS-1:0] w_rin_ra;

  assign w_op        = ir[IR_OP_HI:IR_OP_LO];
  assign w_ra        = ir[IR_RA_HI:IR_RA_LO];
  assign w_rb        = ir[IR_RB_HI:IR_RB_LO];
  assign w_rc        = ir[IR_RC_HI:IR_RC_LO];
  assign w_unused_ir = ^ir[IR_RC_LO-1:0];

  assign w_is_alu   = is_alu_op(w_op);
  assign w_is_nop   = (w_op == OP_NOP);
  assign w_is_halt  = (w_op == OP_HALT);
  assign w_is_legal = is_legal_op(w_op);

  // An instruction retires at the end of T5 (ALU) or at the end of T3 (NOP).
  assign w_retire = (r_state == S_T5) || ((r_state == S_T3) && w_is_nop);

  // Register bus selects: rb in T3, rc in T4 share the Rout bus; ra writes in T5.
  reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_dec_rb (
    .i_field  (w_rb),
    .i_en     ((r_state == S_T3) && w_is_alu),
    .o_onehot (w_rout_rb)
  );

  reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_dec_rc (
    .i_field  (w_rc),
    .i_en     (r_state == S_T4),
    .o_onehot (w_rout_rc)
  );

  reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_dec_ra (
    .i_field  (w_ra),
    .i_en     (r_state == S_T5),
    .o_onehot (w_rin_ra)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_count <= '0;
    end else if (w_retire) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (run) w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1:   if (mem_ready) w_next = S_T2;
      S_T2:   w_next = S_T3;
      S_T3: begin
        if (w_is_alu) begin
          w_next = S_T4;
        end else if (w_is_halt) begin
          w_next = S_HALT;
        end else begin
          w_next = run ? S_T0 : S_IDLE;
        end
      end
      S_T4:   w_next = S_T5;
      S_T5:   w_next = run ? S_T0 : S_IDLE;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    PCout   = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    Zlo_out = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    opcode  = '0;
    halted  = 1'b0;
    unique case (r_state)
      S_T0: begin
        PCout = 1'b1;
        IncPC = 1'b1;
        MARin = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlo_out = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: Yin = w_is_alu;
      S_T4: begin
        opcode = w_op;
        Zin    = 1'b1;
      end
      S_T5:   Zlo_out = 1'b1;
      S_HALT: halted  = 1'b1;
      default: ;
    endcase
  end

  assign Rout        = w_rout_rb | w_rout_rc;
  assign Rin         = w_rin_ra;
  // T2 sees the previously fetched word (advisory); T3 is authoritative.
  assign illegal     = ((r_state == S_T2) || (r_state == S_T3)) && !w_is_legal;
  assign instr_count = r_count;

endmodule
